mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency memory between the IF-stage instruction fetch and the MEM-stage data access. Each requester uses a req/ack handshake. Every transaction runs through a four-state FSM: IDLE, ISSUE, WAIT, DONE. Data requests normally take priority, and a starvation counter guarantees forward progress for fetch. Per-requester stall outputs let the pipeline freeze stages while their access is outstanding.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and data access.
// Data wins ties until fetch has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_ack_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wmask_i,
    output logic                d_ack_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                if_stall_o,
    output logic                d_stall_o,
    output logic                busy_o
);

    localparam int MW    = DATA_W / 8;
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               gnt_fetch_q, gnt_fetch_d;
    logic               txn_we_q, txn_we_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [MW-1:0]      mem_wmask_q, mem_wmask_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               if_ack_q, if_ack_d;
    logic               d_ack_q, d_ack_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               busy_q, busy_d;
    logic               pick_fetch_s;

    // Fetch wins when it is the only requester or has been starved to the limit
    assign pick_fetch_s = if_req_i & (~d_req_i | (starve_q == STV_W'(STARVE_LIMIT)));

    assign if_ack_o    = if_ack_q;
    assign d_ack_o     = d_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wmask_o = mem_wmask_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign if_stall_o  = if_req_i & ~if_ack_q & ~reset_i;
    assign d_stall_o   = d_req_i & ~d_ack_q & ~reset_i;

    // Transaction FSM: arbitration, memory strobe, latency count and completion
    always_comb begin
        state_d     = state_q;
        gnt_fetch_d = gnt_fetch_q;
        txn_we_d    = txn_we_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wmask_d = {MW{1'b0}};
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (if_req_i || d_req_i) begin
                    state_d  = ST_ISSUE;
                    mem_en_d = 1'b1;
                    if (pick_fetch_s) begin
                        gnt_fetch_d = 1'b1;
                        txn_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        starve_d    = {STV_W{1'b0}};
                    end else begin
                        gnt_fetch_d = 1'b0;
                        txn_we_d    = d_we_i;
                        mem_we_d    = d_we_i;
                        mem_wmask_d = d_we_i ? d_wmask_i : {MW{1'b0}};
                        mem_addr_d  = d_addr_i;
                        mem_wdata_d = d_wdata_i;
                        if (if_req_i && (starve_q != STV_W'(STARVE_LIMIT))) begin
                            starve_d = starve_q + STV_W'(1);
                        end else if (if_req_i) begin
                            starve_d = starve_q;
                        end else begin
                            starve_d = {STV_W{1'b0}};
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                lat_d   = LAT_W'(MEM_LATENCY - 1);
            end
            ST_WAIT: begin
                if (lat_q == {LAT_W{1'b0}}) begin
                    state_d = ST_DONE;
                    if (gnt_fetch_q) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end else if (txn_we_q) begin
                        d_ack_d = 1'b1;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = mem_rdata_i;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            gnt_fetch_q <= 1'b0;
            txn_we_q    <= 1'b0;
            lat_q       <= {LAT_W{1'b0}};
            starve_q    <= {STV_W{1'b0}};
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= {MW{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_fetch_q <= gnt_fetch_d;
            txn_we_q    <= txn_we_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_wmask_q <= mem_wmask_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int LAT   = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_wmask;
    logic        if_ack, d_ack, mem_en, mem_we, if_stall, d_stall, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    logic        a_d_req;
    logic [31:0] a_d_addr;
    logic        a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_if_stall, a_d_stall, a_busy;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_wmask;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_wmask_i(d_wmask), .d_ack_o(d_ack), .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata),
        .if_stall_o(if_stall), .d_stall_o(d_stall), .busy_o(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) dut1 (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(1'b0), .if_addr_i(32'h0), .if_ack_o(a_if_ack), .if_rdata_o(a_if_rdata),
        .d_req_i(a_d_req), .d_we_i(1'b0), .d_addr_i(a_d_addr), .d_wdata_i(32'h0),
        .d_wmask_i(4'h0), .d_ack_o(a_d_ack), .d_rdata_o(a_d_rdata),
        .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
        .mem_wmask_o(a_mem_wmask), .mem_rdata_i(a_mem_rdata),
        .if_stall_o(a_if_stall), .d_stall_o(a_d_stall), .busy_o(a_busy)
    );

    function automatic logic [31:0] init_word(input logic [7:0] i);
        return ({24'h000000, i} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    // Memory device: data valid exactly LAT cycles after the strobe, garbage otherwise
    logic [31:0] dev_mem [256];
    logic        mem_ready = 1'b0;
    logic [31:0] pipe1, pipe2, a_pipe;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(8'(i));
            dev_mem[8'h40] <= 32'hDEADBEEF;
            dev_mem[8'h00] <= 32'hCAFEF00D;
            mem_ready      <= 1'b1;
        end else if (mem_en && mem_we) begin
            dev_mem[mem_addr[9:2]] <= merge(dev_mem[mem_addr[9:2]], mem_wdata, mem_wmask);
        end
        pipe1  <= (mem_en && !mem_we) ? dev_mem[mem_addr[9:2]] : 32'hBAD0BAD0;
        pipe2  <= pipe1;
        a_pipe <= a_mem_en ? init_word(a_mem_addr[9:2]) : 32'hBAD1BAD1;
    end
    assign mem_rdata   = pipe2;
    assign a_mem_rdata = a_pipe;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        fetch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ref_mem [256];
        int          nd;
        int          next_free, issue_c, f_ack_c, d_ack_c, starve;
        logic        f_pend, d_pend, g_fetch, e_we, d_is_wr;
        logic [31:0] e_addr, e_wdata, f_data, d_data, exp_if, exp_d;
        logic [3:0]  e_wmask;
        logic [7:0]  idx;

        vt[0] = '{1'b1, 1'b0, 32'h00000100, 32'h00000000, 4'h0, 32'hDEADBEEF};
        vt[1] = '{1'b0, 1'b1, 32'h00002000, 32'h12345678, 4'h3, 32'h00000000};
        vt[2] = '{1'b0, 1'b0, 32'h00002000, 32'h00000000, 4'h0, 32'hCAFE5678};
        vt[3] = '{1'b0, 1'b1, 32'h00002000, 32'hAABBCCDD, 4'hC, 32'hCAFE5678};
        vt[4] = '{1'b0, 1'b0, 32'h00002000, 32'h00000000, 4'h0, 32'hAABB5678};
        vt[5] = '{1'b1, 1'b0, 32'h00002000, 32'h00000000, 4'h0, 32'hAABB5678};
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));

        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wmask = 4'h0;
        a_d_req = 1'b0; a_d_addr = 32'h0;
        tick(); tick();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_if_ack", if_ack, 1'b0);
        chk1("rst_d_ack", d_ack, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        if_req = 1'b1; #1;
        chk1("rst_if_stall", if_stall, 1'b0);
        if_req = 1'b0;
        reset = 1'b0;

        // Directed single transactions from IDLE
        for (int v = 0; v < 6; v++) begin
            if_req = vt[v].fetch; if_addr = vt[v].addr;
            d_req = !vt[v].fetch; d_we = vt[v].we; d_addr = vt[v].addr;
            d_wdata = vt[v].wdata; d_wmask = vt[v].wmask;
            tick();
            chk1("tbl_issue_en", mem_en, 1'b1);
            chk("tbl_issue_addr", mem_addr, vt[v].addr);
            chk1("tbl_issue_we", mem_we, !vt[v].fetch && vt[v].we);
            chk("tbl_issue_wmask", {28'h0, mem_wmask},
                (!vt[v].fetch && vt[v].we) ? {28'h0, vt[v].wmask} : 32'h0);
            if (!vt[v].fetch && vt[v].we) chk("tbl_issue_wdata", mem_wdata, vt[v].wdata);
            for (int c = 2; c <= 3; c++) begin
                tick();
                chk1("tbl_wait_en", mem_en, 1'b0);
                chk1("tbl_early_ack", vt[v].fetch ? if_ack : d_ack, 1'b0);
            end
            tick();
            chk1("tbl_ack", vt[v].fetch ? if_ack : d_ack, 1'b1);
            chk1("tbl_other_ack", vt[v].fetch ? d_ack : if_ack, 1'b0);
            chk("tbl_rdata", vt[v].fetch ? if_rdata : d_rdata, vt[v].exp_rdata);
            tick();
            chk1("tbl_ack_pulse", vt[v].fetch ? if_ack : d_ack, 1'b0);
            chk1("tbl_idle_busy", busy, 1'b0);
            if_req = 1'b0; d_req = 1'b0;
        end
        tick();

        // Simultaneous requests: data first, fetch in the next IDLE
        if_req = 1'b1; if_addr = 32'h140; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180;
        tick();
        chk("sim_first_addr", mem_addr, 32'h180);
        tick(); tick(); tick();
        chk1("sim_d_ack", d_ack, 1'b1);
        chk1("sim_if_ack_early", if_ack, 1'b0);
        chk1("sim_if_stall", if_stall, 1'b1);
        chk("sim_d_rdata", d_rdata, init_word(8'h60));
        tick();
        d_req = 1'b0;
        tick();
        chk1("sim_fetch_en", mem_en, 1'b1);
        chk("sim_fetch_addr", mem_addr, 32'h140);
        tick(); tick(); tick();
        chk1("sim_if_ack", if_ack, 1'b1);
        chk("sim_if_rdata", if_rdata, init_word(8'h50));
        chk1("sim_if_stall_ack", if_stall, 1'b0);
        tick();
        if_req = 1'b0;
        tick();

        // Starvation: fetch held while data streams back-to-back reads
        if_req = 1'b1; if_addr = 32'h144; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; nd = 0;
        for (int s = 0; s < 6; s++) begin
            tick();
            chk1("stv_issue_en", mem_en, 1'b1);
            chk("stv_grant_addr", mem_addr, (s == 4) ? 32'h144 : 32'h200 + 32'(nd) * 32'd4);
            tick(); tick(); tick();
            if (s == 4) begin
                chk1("stv_if_ack", if_ack, 1'b1);
            end else begin
                chk1("stv_d_ack", d_ack, 1'b1);
                chk("stv_d_rdata", d_rdata, init_word(8'h80 + 8'(nd)));
                nd++;
            end
            tick();
            if (s == 4) if_req = 1'b0;
            d_addr = 32'h200 + 32'(nd) * 32'd4;
            if (nd == 5) d_req = 1'b0;
        end
        tick();

        // Reset while in WAIT, then a clean fetch
        if_req = 1'b1; if_addr = 32'h1C0;
        tick(); tick();
        reset = 1'b1; #1;
        chk1("rw_busy", busy, 1'b0);
        chk1("rw_mem_en", mem_en, 1'b0);
        chk1("rw_if_ack", if_ack, 1'b0);
        chk1("rw_d_ack", d_ack, 1'b0);
        chk1("rw_if_stall", if_stall, 1'b0);
        chk("rw_if_rdata", if_rdata, 32'h0);
        tick(); tick();
        chk1("rw_busy_hold", busy, 1'b0);
        if_addr = 32'h1C4; reset = 1'b0;
        tick();
        chk("rw_new_addr", mem_addr, 32'h1C4);
        tick(); tick();
        chk1("rw_no_early_ack", if_ack, 1'b0);
        tick();
        chk1("rw_if_ack", if_ack, 1'b1);
        chk("rw_if_rdata_new", if_rdata, init_word(8'h71));
        tick();
        if_req = 1'b0;
        tick();

        // One-cycle latency build: ack three cycles after sampling
        a_d_req = 1'b1; a_d_addr = 32'h1D0;
        tick();
        chk1("l1_issue_en", a_mem_en, 1'b1);
        tick();
        chk1("l1_no_ack", a_d_ack, 1'b0);
        chk1("l1_busy", a_busy, 1'b1);
        tick();
        chk1("l1_ack", a_d_ack, 1'b1);
        chk("l1_rdata", a_d_rdata, init_word(8'h74));
        tick();
        a_d_req = 1'b0;
        chk1("l1_ack_pulse", a_d_ack, 1'b0);

        // Randomized traffic against a transaction-level model
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        f_pend = 1'b0; d_pend = 1'b0; d_is_wr = 1'b0;
        next_free = 0; issue_c = -1000; f_ack_c = -1000; d_ack_c = -1000; starve = 0;
        exp_if = 32'h0; exp_d = 32'h0; f_data = 32'h0; d_data = 32'h0;
        e_addr = 32'h0; e_wdata = 32'h0; e_wmask = 4'h0; e_we = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (f_pend && f_ack_c == k - 1) f_pend = 1'b0;
            if (d_pend && d_ack_c == k - 1) d_pend = 1'b0;
            if (!f_pend && $urandom_range(0, 2) == 0) begin
                f_pend = 1'b1;
                if_addr = 32'h300 + 32'($urandom_range(0, 15)) * 32'd4;
            end
            if (!d_pend && $urandom_range(0, 3) != 0) begin
                d_pend = 1'b1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = 32'h300 + 32'($urandom_range(0, 15)) * 32'd4;
                d_wdata = $urandom;
                d_wmask = 4'($urandom_range(0, 15));
            end
            if_req = f_pend; d_req = d_pend;
            if (k >= next_free && (f_pend || d_pend)) begin
                g_fetch = f_pend && (!d_pend || starve == LIMIT);
                if (g_fetch) starve = 0;
                else if (f_pend) starve = (starve < LIMIT) ? starve + 1 : starve;
                else starve = 0;
                issue_c = k + 1;
                next_free = k + LAT + 3;
                e_addr = g_fetch ? if_addr : d_addr;
                e_we = !g_fetch && d_we;
                e_wmask = e_we ? d_wmask : 4'h0;
                e_wdata = d_wdata;
                idx = e_addr[9:2];
                if (g_fetch) begin
                    f_ack_c = k + LAT + 2;
                    f_data = ref_mem[idx];
                end else begin
                    d_ack_c = k + LAT + 2;
                    d_is_wr = d_we;
                    if (d_we) ref_mem[idx] = merge(ref_mem[idx], d_wdata, d_wmask);
                    else d_data = ref_mem[idx];
                end
            end
            if (k == f_ack_c) exp_if = f_data;
            if (k == d_ack_c && !d_is_wr) exp_d = d_data;
            chk1("rnd_mem_en", mem_en, k == issue_c);
            if (k == issue_c) begin
                chk("rnd_mem_addr", mem_addr, e_addr);
                chk1("rnd_mem_we", mem_we, e_we);
                chk("rnd_mem_wmask", {28'h0, mem_wmask}, {28'h0, e_wmask});
                if (e_we) chk("rnd_mem_wdata", mem_wdata, e_wdata);
            end
            chk1("rnd_if_ack", if_ack, k == f_ack_c);
            chk1("rnd_d_ack", d_ack, k == d_ack_c);
            chk("rnd_if_rdata", if_rdata, exp_if);
            chk("rnd_d_rdata", d_rdata, exp_d);
            chk1("rnd_busy", busy, k >= issue_c && k < next_free);
            #1;
            chk1("rnd_if_stall", if_stall, f_pend && k != f_ack_c);
            chk1("rnd_d_stall", d_stall, d_pend && k != d_ack_c);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
